// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control FSM for a multicycle RV32I-style datapath. Sequences each
//   instruction through FETCH / DECODE / execute / memory / writeback states
//   and drives the datapath selects and enables for the current state. All
//   datapath controls are decoded from the state register (plus the memory
//   ready strobe and branch flags where a state needs them) so that reset and
//   mem_ready take effect within the same cycle.
//
// Parameters
//   HALT_ON_ILLEGAL : 1 = stay in TRAP until reset, 0 = leave TRAP after one cycle
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   opcode, funct3       : instruction fields from the instruction register
//   alu_zero/lt/ltu      : ALU comparison flags used by branches
//   mem_ready            : memory completion strobe (only meaningful with mem_req)
//   mem_req/mem_we       : memory request / write
//   addr_sel             : memory address source (0 PC, 1 ALU)
//   ir_write, pc_write   : IR/old_pc load, PC load
//   pc_src               : 0 PC+4, 1 old_pc+imm, 2 ALU & ~1
//   reg_write, wb_sel    : register write enable, writeback source
//   alu_a_sel, alu_b_sel : ALU operand selects
//   alu_op, imm_type     : ALU operation, immediate format
//   illegal, halted      : trap indication
//   retire_count         : retired instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_type,
    output logic        illegal,
    output logic        halted,
    output logic [31:0] retire_count
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_TRAP
    } state_t;

    state_t state;
    logic   br_legal;
    logic   br_taken;
    logic   retire;

    // Branch condition from funct3; 010/011 are not branch encodings.
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = ~alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = ~alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = ~alu_ltu;
            default: br_legal = 1'b0;
        endcase
    end

    // Cycles in which the current instruction completes.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_WB_ALU, S_WB_MEM, S_JAL, S_JALR: retire = 1'b1;
            S_MEM_WR:                          retire = mem_ready;
            S_BRANCH:                          retire = br_legal;
            default:                           retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            retire_count <= 32'd0;
        end else begin
            if (retire)
                retire_count <= retire_count + 32'd1;
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        7'b0110011:             state <= S_EXEC_R;
                        7'b0010011:             state <= S_EXEC_I;
                        7'b0000011, 7'b0100011: state <= S_MEM_ADDR;
                        7'b1100011:             state <= S_BRANCH;
                        7'b1101111:             state <= S_JAL;
                        7'b1100111:             state <= S_JALR;
                        default:                state <= S_TRAP;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
                // opcode bit 5 separates store (0100011) from load (0000011).
                S_MEM_ADDR: state <= opcode[5] ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_BRANCH:   state <= br_legal ? S_FETCH : S_TRAP;
                S_TRAP:     if (!HALT_ON_ILLEGAL) state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Control decode; everything is forced low while reset is held so an
    // in-flight access is dropped in the cycle reset arrives.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = 2'd0;
        imm_type  = 3'd0;
        illegal   = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC_R: alu_op = 2'd2;
                S_EXEC_I: begin
                    alu_b_sel = 1'b1;
                    imm_type  = 3'd1;
                    alu_op    = 2'd2;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_MEM_ADDR: begin
                    alu_b_sel = 1'b1;
                    imm_type  = opcode[5] ? 3'd2 : 3'd1;
                end
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                end
                S_BRANCH: begin
                    alu_op   = 2'd1;
                    imm_type = 3'd3;
                    pc_write = br_legal & br_taken;
                    pc_src   = (br_legal & br_taken) ? 2'd1 : 2'd0;
                end
                S_JAL: begin
                    imm_type  = 3'd4;
                    pc_write  = 1'b1;
                    pc_src    = 2'd1;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                end
                S_JALR: begin
                    alu_b_sel = 1'b1;
                    imm_type  = 3'd1;
                    pc_write  = 1'b1;
                    pc_src    = 2'd2;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    halted  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Drives directed and randomized instruction streams into two controllers
//   (halting and non-halting trap variants) and compares every cycle's
//   control outputs and retire counter against a per-instruction reference
//   sequence built from the controller's behavioural rules.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
    logic        alu_a_sel, alu_b_sel, illegal, halted;
    logic [1:0]  pc_src, wb_sel, alu_op;
    logic [2:0]  imm_type;
    logic [31:0] retire_count;

    logic        n_mem_req, n_mem_we, n_addr_sel, n_ir_write, n_pc_write, n_reg_write;
    logic        n_alu_a_sel, n_alu_b_sel, n_illegal, n_halted;
    logic [1:0]  n_pc_src, n_wb_sel, n_alu_op;
    logic [2:0]  n_imm_type;
    logic [31:0] n_retire_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt = 32'd0;
    bit          chk_nh  = 1'b1;

    always #5 clk = ~clk;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .imm_type(imm_type),
        .illegal(illegal), .halted(halted), .retire_count(retire_count)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) u_nh (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .addr_sel(n_addr_sel), .ir_write(n_ir_write),
        .pc_write(n_pc_write), .pc_src(n_pc_src), .reg_write(n_reg_write), .wb_sel(n_wb_sel),
        .alu_a_sel(n_alu_a_sel), .alu_b_sel(n_alu_b_sel), .alu_op(n_alu_op), .imm_type(n_imm_type),
        .illegal(n_illegal), .halted(n_halted), .retire_count(n_retire_count)
    );

    logic [18:0] ctrl, ctrl_nh;
    assign ctrl    = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
                      wb_sel, alu_a_sel, alu_b_sel, alu_op, imm_type, illegal, halted};
    assign ctrl_nh = {n_mem_req, n_mem_we, n_addr_sel, n_ir_write, n_pc_write, n_pc_src,
                      n_reg_write, n_wb_sel, n_alu_a_sel, n_alu_b_sel, n_alu_op, n_imm_type,
                      n_illegal, n_halted};

    // Expected control word; alu_a_sel is never asserted by any state.
    function automatic logic [18:0] ev(input logic mreq, mwe, asel, irw, pcw,
                                       input logic [1:0] pcs, input logic rw,
                                       input logic [1:0] wbs, input logic bsel,
                                       input logic [1:0] aop, input logic [2:0] imm,
                                       input logic ill, hlt);
        return {mreq, mwe, asel, irw, pcw, pcs, rw, wbs, 1'b0, bsel, aop, imm, ill, hlt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One controller cycle: called at a falling edge with inputs already set.
    task automatic cyc(input string tag, input logic [18:0] e, input bit ret);
        #1;
        chk(tag, 32'(ctrl), 32'(e));
        chk({tag, "_cnt"}, retire_count, exp_cnt);
        if (chk_nh) begin
            chk({tag, "_nh"}, 32'(ctrl_nh), 32'(e));
            chk({tag, "_nh_cnt"}, n_retire_count, exp_cnt);
        end
        @(posedge clk);
        if (ret) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_same_cycle", 32'(ctrl), 32'd0);
        chk("rst_same_cycle_nh", 32'(ctrl_nh), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_held", 32'(ctrl), 32'd0);
        chk("rst_cnt", retire_count, 32'd0);
        chk("rst_cnt_nh", n_retire_count, 32'd0);
        rst = 1'b0;
        mem_ready = 1'b0;
        exp_cnt = 32'd0;
        #1;
        chk("post_rst_fetch", 32'(ctrl), 32'(ev(1,0,0,0,0,0,0,0,0,0,0,0,0)));
        chk("post_rst_fetch_nh", 32'(ctrl_nh), 32'(ev(1,0,0,0,0,0,0,0,0,0,0,0,0)));
        @(negedge clk);
    endtask

    // Fetch with wf wait cycles, then decode.
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input int wf);
        opcode = op;
        funct3 = f3;
        for (int i = 0; i < wf; i++) begin
            mem_ready = 1'b0;
            cyc("fetch_wait", ev(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
        end
        mem_ready = 1'b1;
        cyc("fetch_ready", ev(1,0,0,1,1,0,0,0,0,0,0,0,0), 1'b0);
        mem_ready = 1'($urandom);
        cyc("decode", 19'd0, 1'b0);
    endtask

    // Full legal instruction: reference sequence built per instruction class.
    task automatic run_inst(input logic [6:0] op, input logic [2:0] f3,
                            input logic z, lt, ltu, input int wf, wm);
        bit tk;
        alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        fetch_decode(op, f3, wf);
        case (op)
            OP_R: begin
                mem_ready = 1'($urandom);
                cyc("exec_r", ev(0,0,0,0,0,0,0,0,0,2,0,0,0), 1'b0);
                cyc("wb_alu", ev(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b1);
            end
            OP_I: begin
                mem_ready = 1'($urandom);
                cyc("exec_i", ev(0,0,0,0,0,0,0,0,1,2,1,0,0), 1'b0);
                cyc("wb_alu", ev(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b1);
            end
            OP_LD, OP_ST: begin
                mem_ready = 1'($urandom);
                cyc("mem_addr", ev(0,0,0,0,0,0,0,0,1,0,(op == OP_ST) ? 3'd2 : 3'd1,0,0), 1'b0);
                for (int i = 0; i < wm; i++) begin
                    mem_ready = 1'b0;
                    cyc("mem_wait", ev(1,(op == OP_ST),1,0,0,0,0,0,0,0,0,0,0), 1'b0);
                end
                mem_ready = 1'b1;
                cyc("mem_done", ev(1,(op == OP_ST),1,0,0,0,0,0,0,0,0,0,0), op == OP_ST);
                if (op == OP_LD) begin
                    mem_ready = 1'($urandom);
                    cyc("wb_mem", ev(0,0,0,0,0,0,1,1,0,0,0,0,0), 1'b1);
                end
            end
            OP_BR: begin
                case (f3)
                    3'd0: tk = z;
                    3'd1: tk = !z;
                    3'd4: tk = lt;
                    3'd5: tk = !lt;
                    3'd6: tk = ltu;
                    default: tk = !ltu;
                endcase
                cyc("branch", ev(0,0,0,0,tk,tk ? 2'd1 : 2'd0,0,0,0,1,3,0,0), 1'b1);
            end
            OP_JAL:  cyc("jal",  ev(0,0,0,0,1,1,1,2,0,0,4,0,0), 1'b1);
            default: cyc("jalr", ev(0,0,0,0,1,2,1,2,1,0,1,0,0), 1'b1);
        endcase
        mem_ready = 1'b0;
    endtask

    // Both controllers have just entered TRAP at this falling edge.
    task automatic trap_check(input string tag);
        chk_nh = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk({tag, "_halt"}, 32'(ctrl), 32'(ev(0,0,0,0,0,0,0,0,0,0,0,1,1)));
            chk({tag, "_halt_cnt"}, retire_count, exp_cnt);
            chk({tag, "_nohalt"}, 32'(ctrl_nh),
                (i == 0) ? 32'(ev(0,0,0,0,0,0,0,0,0,0,0,1,1)) : 32'(ev(1,0,0,0,0,0,0,0,0,0,0,0,0)));
            chk({tag, "_nohalt_cnt"}, n_retire_count, exp_cnt);
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
        chk_nh = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // ADDI with three fetch wait cycles
        run_inst(OP_I, 3'd0, 0, 0, 0, 3, 0);
        chk("addi_retired", retire_count, 32'd1);

        // LW then SW, memory ready immediately
        run_inst(OP_LD, 3'd2, 0, 0, 0, 0, 0);
        run_inst(OP_ST, 3'd2, 0, 0, 0, 0, 0);
        #1 chk("lw_sw_retired", retire_count, 32'd3);
        @(negedge clk);

        // BEQ taken, BNE not taken, both with alu_zero=1
        run_inst(OP_BR, 3'd0, 1, 0, 0, 0, 0);
        run_inst(OP_BR, 3'd1, 1, 0, 0, 0, 0);

        // randomized legal instruction stream
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_ST;
                4: op = OP_BR;
                5: op = OP_JAL;
                default: op = OP_JALR;
            endcase
            f3 = 3'($urandom);
            if (op == OP_BR && (f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd7;
            run_inst(op, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // undecodable opcode
        fetch_decode(7'b0000000, 3'd0, 1);
        trap_check("trap_op0");

        // branch with funct3 010: no PC write, no retire, then TRAP
        run_inst(OP_I, 3'd0, 0, 0, 0, 0, 0);
        alu_zero = 1'b1; alu_lt = 1'b1; alu_ltu = 1'b1;
        fetch_decode(OP_BR, 3'b010, 0);
        cyc("branch_bad_f3", ev(0,0,0,0,0,0,0,0,0,1,3,0,0), 1'b0);
        trap_check("trap_br");

        // reset in the middle of a load's memory wait
        run_inst(OP_R, 3'd0, 0, 0, 0, 0, 0);
        alu_zero = 1'b0;
        fetch_decode(OP_LD, 3'd2, 0);
        mem_ready = 1'b0;
        cyc("mem_addr_pre_rst", ev(0,0,0,0,0,0,0,0,1,0,1,0,0), 1'b0);
        cyc("mem_rd_pre_rst", ev(1,0,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
        do_reset();

        // retire counter wrap through a JAL
        opcode = OP_JAL;
        mem_ready = 1'b1;
        cyc("wrap_fetch", ev(1,0,0,1,1,0,0,0,0,0,0,0,0), 1'b0);
        force u_dut.retire_count = 32'hFFFF_FFFF;
        force u_nh.retire_count  = 32'hFFFF_FFFF;
        #1;
        release u_dut.retire_count;
        release u_nh.retire_count;
        exp_cnt = 32'hFFFF_FFFF;
        mem_ready = 1'b0;
        cyc("wrap_decode", 19'd0, 1'b0);
        cyc("wrap_jal", ev(0,0,0,0,1,1,1,2,0,0,4,0,0), 1'b1);
        cyc("wrap_after", ev(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
        chk("wrap_zero", retire_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
